retire_perf_monitor: RTL and testbench

Synthesizable retirement monitor for the DandRiscv core. It replaces ad-hoc testbench instruction counting with a parametrised block that counts cycles and retired instructions across RETIRE_PORTS writeback lanes and runs a hang watchdog. It also buffers retired PCs in a trace FIFO that is drained through a valid/ready port. The block sits beside the core in DandSocSimple, is fed from the writeback stage, and is readable by the simulation bench or a debug bus.

---
 rtl/retire_perf_monitor.sv | 139 +++++++++++++
 tb/tb_retire_perf_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/retire_perf_monitor.sv
`default_nettype none
// ============================================================================
// retire_perf_monitor: cycle/instruction counters, hang watchdog, retired-PC trace FIFO
// Rev 1.0
// ============================================================================
module retire_perf_monitor #(
  parameter int RETIRE_PORTS = 2,
  parameter int PC_WIDTH     = 64,
  parameter int CNT_WIDTH    = 64,
  parameter int TIMEOUT      = 1024,
  parameter int TRACE_DEPTH  = 16,
  parameter int DROP_WIDTH   = 16
) (
  input  logic                             io_axiClk,
  input  logic                             io_asyncResetn,
  input  logic                             io_enable,
  input  logic                             io_clear,
  input  logic [RETIRE_PORTS-1:0]          io_retire_valid,
  input  logic [RETIRE_PORTS*PC_WIDTH-1:0] io_retire_pc,
  output logic [CNT_WIDTH-1:0]             io_cycleCnt,
  output logic [CNT_WIDTH-1:0]             io_instrCnt,
  output logic                             io_hang,
  output logic                             io_trace_valid,
  input  logic                             io_trace_ready,
  output logic [PC_WIDTH-1:0]              io_trace_pc,
  output logic [DROP_WIDTH-1:0]            io_trace_drop
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int ADDR_W = $clog2(TRACE_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int LANE_W = $clog2(RETIRE_PORTS + 1);

  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  instr_q, instr_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  hang_q, hang_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PC_WIDTH-1:0]   mem_q [TRACE_DEPTH];

  logic [PTR_W-1:0]        occ;
  logic [PTR_W-1:0]        free;
  logic [PTR_W-1:0]        npush;
  logic [PTR_W-1:0]        slot;
  logic [LANE_W-1:0]       nvalid;
  logic [LANE_W-1:0]       ndrop;
  logic [RETIRE_PORTS-1:0] wr_en;
  logic [ADDR_W-1:0]       wr_addr [RETIRE_PORTS];
  logic [DROP_WIDTH:0]     drop_sum;
  logic                    pop;

  assign occ            = wr_ptr_q - rd_ptr_q;
  assign free           = PTR_W'(TRACE_DEPTH) - occ;
  assign io_trace_valid = (occ != '0);
  assign pop            = io_trace_valid && io_trace_ready;
  assign io_trace_pc    = io_trace_valid ? mem_q[rd_ptr_q[ADDR_W-1:0]] : '0;

  // Lanes claim free slots in ascending order; room freed by a same-cycle pop is not reused.
  always_comb begin
    nvalid = '0;
    npush  = '0;
    ndrop  = '0;
    slot   = '0;
    wr_en  = '0;
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      wr_addr[i] = '0;
      if (io_enable && io_retire_valid[i]) begin
        nvalid = nvalid + LANE_W'(1);
        if (npush < free) begin
          slot       = wr_ptr_q + npush;
          wr_en[i]   = 1'b1;
          wr_addr[i] = slot[ADDR_W-1:0];
          npush      = npush + PTR_W'(1);
        end else begin
          ndrop = ndrop + LANE_W'(1);
        end
      end
    end
  end

  always_comb begin
    cycle_d  = io_enable ? cycle_q + CNT_WIDTH'(1) : cycle_q;
    instr_d  = instr_q + CNT_WIDTH'(nvalid);
    idle_d   = idle_q;
    if (io_enable) begin
      if (|io_retire_valid)              idle_d = '0;
      else if (idle_q != IDLE_W'(TIMEOUT)) idle_d = idle_q + IDLE_W'(1);
    end
    hang_d   = hang_q | (idle_d == IDLE_W'(TIMEOUT));
    drop_sum = {1'b0, drop_q} + (DROP_WIDTH + 1)'(ndrop);
    drop_d   = drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
    wr_ptr_d = wr_ptr_q + npush;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      cycle_q  <= '0;
      instr_q  <= '0;
      idle_q   <= '0;
      hang_q   <= 1'b0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (io_clear) begin
      cycle_q  <= '0;
      instr_q  <= '0;
      idle_q   <= '0;
      hang_q   <= 1'b0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
      idle_q   <= idle_d;
      hang_q   <= hang_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observable between the pointers.
  always_ff @(posedge io_axiClk) begin
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      if (wr_en[i]) mem_q[wr_addr[i]] <= io_retire_pc[i*PC_WIDTH +: PC_WIDTH];
    end
  end

  assign io_cycleCnt   = cycle_q;
  assign io_instrCnt   = instr_q;
  assign io_hang       = hang_q;
  assign io_trace_drop = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_retire_perf_monitor.sv
`default_nettype none
// ============================================================================
// tb_retire_perf_monitor: directed vectors for retire_perf_monitor (2 lanes, depth 4, timeout 8)
// Rev 1.0
// ============================================================================
module tb_retire_perf_monitor;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic [1:0]   vld;
  logic [63:0]  pc0;
  logic [63:0]  pc1;
  logic         rdy;
  logic [63:0]  cyc;
  logic [63:0]  ins;
  logic         hang;
  logic         tvalid;
  logic [63:0]  tpc;
  logic [3:0]   drop;

  int nchecks = 0;
  int nfail   = 0;

  retire_perf_monitor #(
    .RETIRE_PORTS(2), .PC_WIDTH(64), .CNT_WIDTH(64),
    .TIMEOUT(8), .TRACE_DEPTH(4), .DROP_WIDTH(4)
  ) dut (
    .io_axiClk(clk), .io_asyncResetn(rst_n), .io_enable(en), .io_clear(clr),
    .io_retire_valid(vld), .io_retire_pc({pc1, pc0}),
    .io_cycleCnt(cyc), .io_instrCnt(ins), .io_hang(hang),
    .io_trace_valid(tvalid), .io_trace_ready(rdy), .io_trace_pc(tpc),
    .io_trace_drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic        rdy;
    logic [1:0]  vld;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic [63:0] cyc;
    logic [63:0] ins;
    logic        hang;
    logic        tv;
    logic [63:0] tpc;
    logic [3:0]  drop;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] e_cyc, input logic [63:0] e_ins,
                         input logic e_hang, input logic e_tv, input logic [63:0] e_tpc,
                         input logic [3:0] e_drop);
    chk({tag, ".cycleCnt"}, cyc, e_cyc);
    chk({tag, ".instrCnt"}, ins, e_ins);
    chk({tag, ".hang"}, {63'd0, hang}, {63'd0, e_hang});
    chk({tag, ".trace_valid"}, {63'd0, tvalid}, {63'd0, e_tv});
    chk({tag, ".trace_pc"}, tpc, e_tpc);
    chk({tag, ".drop"}, {60'd0, drop}, {60'd0, e_drop});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; clr = 1'b0; vld = 2'b00; pc0 = '0; pc1 = '0; rdy = 1'b0;
  endtask

  initial begin
    // en clr rdy vld pc0 pc1 | cyc ins hang tv tpc drop
    vecs.push_back('{1, 0, 0, 2'b11, 64'h100, 64'h104, 1, 2, 0, 1, 64'h100, 0});
    vecs.push_back('{1, 0, 0, 2'b11, 64'h108, 64'h10C, 2, 4, 0, 1, 64'h100, 0});
    vecs.push_back('{1, 0, 0, 2'b11, 64'h110, 64'h114, 3, 6, 0, 1, 64'h100, 2});
    vecs.push_back('{0, 0, 1, 2'b00, 64'h0,   64'h0,   3, 6, 0, 1, 64'h104, 2});
    vecs.push_back('{0, 0, 1, 2'b00, 64'h0,   64'h0,   3, 6, 0, 1, 64'h108, 2});
    vecs.push_back('{0, 0, 1, 2'b00, 64'h0,   64'h0,   3, 6, 0, 1, 64'h10C, 2});
    vecs.push_back('{0, 0, 1, 2'b00, 64'h0,   64'h0,   3, 6, 0, 0, 64'h0,   2});
    vecs.push_back('{0, 0, 1, 2'b11, 64'h150, 64'h154, 3, 6, 0, 0, 64'h0,   2});
    vecs.push_back('{1, 0, 0, 2'b11, 64'h180, 64'h184, 4, 8, 0, 1, 64'h180, 2});
    vecs.push_back('{1, 0, 0, 2'b11, 64'h188, 64'h18C, 5, 10, 0, 1, 64'h180, 2});
    vecs.push_back('{1, 0, 1, 2'b01, 64'h200, 64'h0,   6, 11, 0, 1, 64'h184, 3});
    vecs.push_back('{1, 0, 0, 2'b10, 64'h0,   64'h204, 7, 12, 0, 1, 64'h184, 3});
    vecs.push_back('{0, 0, 1, 2'b00, 64'h0,   64'h0,   7, 12, 0, 1, 64'h188, 3});
    vecs.push_back('{0, 0, 1, 2'b00, 64'h0,   64'h0,   7, 12, 0, 1, 64'h18C, 3});
    vecs.push_back('{0, 0, 1, 2'b00, 64'h0,   64'h0,   7, 12, 0, 1, 64'h204, 3});
    vecs.push_back('{1, 0, 0, 2'b11, 64'h300, 64'h304, 8, 14, 0, 1, 64'h204, 3});
    vecs.push_back('{1, 1, 1, 2'b11, 64'h350, 64'h354, 0, 0,  0, 0, 64'h0,   0});
    vecs.push_back('{1, 0, 0, 2'b01, 64'h400, 64'h0,   1, 1,  0, 1, 64'h400, 0});

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // 100 enabled cycles, lane1 on even cycles: 4 PCs fit, 146 dropped -> drop saturates
    for (int i = 0; i < 100; i++) begin
      en = 1'b1;
      vld = {(i % 2 == 0), 1'b1};
      pc0 = 64'h1000 + 64'(i);
      pc1 = 64'h2000 + 64'(i);
      step();
    end
    chk_all("count100", 100, 150, 0, 1, 64'h1000, 4'hF);

    idle_inputs();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_all("clear1", 0, 0, 0, 0, 0, 0);

    en = 1'b1;
    repeat (7) step();
    chk("wd7.hang", {63'd0, hang}, 64'd0);
    step();
    chk("wd8.hang", {63'd0, hang}, 64'd1);
    chk("wd8.cycleCnt", cyc, 64'd8);
    vld = 2'b01; pc0 = 64'h500;
    step();
    chk("wdret.hang", {63'd0, hang}, 64'd1);
    chk("wdret.instrCnt", ins, 64'd1);
    vld = 2'b00;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_all("wdclear", 0, 0, 0, 0, 0, 0);
    en = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; clr = vecs[i].clr; rdy = vecs[i].rdy;
      vld = vecs[i].vld; pc0 = vecs[i].pc0; pc1 = vecs[i].pc1;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].cyc, vecs[i].ins, vecs[i].hang,
              vecs[i].tv, vecs[i].tpc, vecs[i].drop);
    end

    // Build instrCnt=37 with 3 FIFO entries, then reset asynchronously between edges
    idle_inputs();
    clr = 1'b1;
    step();
    clr = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      vld = (i == 18) ? 2'b01 : 2'b11;
      pc0 = 64'h3000 + 64'(16 * i);
      pc1 = 64'h3008 + 64'(16 * i);
      step();
    end
    idle_inputs();
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("pre_rst.instrCnt", ins, 64'd37);
    chk("pre_rst.trace_pc", tpc, 64'h3008);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    en = 1'b1; vld = 2'b01; pc0 = 64'h600;
    #2;
    rst_n = 1'b1;
    step();
    chk_all("post_rst", 1, 1, 0, 1, 64'h600, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
`default_nettype wire
